// File: rtl/ddr2_24x64_8_phy_alt_mem_phy_pll_phase_arbiter.sv
// PLL dynamic phase-shift arbiter: calibration vs. mimic tracking.
// Optional busy-high watchdog enabled by PLL_PHASE_ARB_TIMEOUT_EN.
module ddr2_24x64_8_phy_alt_mem_phy_pll_phase_arbiter #(
  parameter int CLOCK_INDEX_WIDTH = 4,
  parameter int STEP_CNT_WIDTH    = 6,
  parameter int META_REGS         = 2,
  parameter int BUSY_WAIT_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                         seq_clk,
  input  logic                         reset_seq,
  input  logic                         cal_req,
  input  logic [CLOCK_INDEX_WIDTH-1:0] cal_clk_index,
  input  logic                         cal_inc_dec_n,
  input  logic [STEP_CNT_WIDTH-1:0]    cal_num_steps,
  output logic                         cal_grant,
  output logic                         cal_ack,
  input  logic                         trk_req,
  input  logic [CLOCK_INDEX_WIDTH-1:0] trk_clk_index,
  input  logic                         trk_inc_dec_n,
  input  logic [STEP_CNT_WIDTH-1:0]    trk_num_steps,
  output logic                         trk_grant,
  output logic                         trk_ack,
  input  logic                         phs_shft_busy,
  output logic                         seq_pll_start_reconfig,
  output logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select,
  output logic                         seq_pll_inc_dec_n,
  output logic                         arb_busy,
  output logic                         arb_timeout_err
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > BUSY_WAIT_CYCLES) ?
                           TIMEOUT_CYCLES : BUSY_WAIT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [META_REGS-1:0]         sync_q, sync_d;
  logic                         last_trk_q, last_trk_d;
  logic                         own_trk_q, own_trk_d;
  logic [STEP_CNT_WIDTH-1:0]    rem_q, rem_d;
  logic [TMR_W-1:0]             tmr_q, tmr_d;
  logic                         start_q, start_d;
  logic [CLOCK_INDEX_WIDTH-1:0] sel_q, sel_d;
  logic                         inc_q, inc_d;
  logic                         cal_grant_q, cal_grant_d;
  logic                         trk_grant_q, trk_grant_d;
  logic                         cal_ack_q, cal_ack_d;
  logic                         trk_ack_q, trk_ack_d;
  logic                         busy_q, busy_d;
  logic                         err_q, err_d;

  logic busy_s;
  logic pick_cal;
  logic pick_trk;
  logic [STEP_CNT_WIDTH-1:0] pick_steps;

  assign busy_s = sync_q[META_REGS-1];

  // Round robin on a tie: the requester not served last wins.
  assign pick_cal = cal_req & (~trk_req | last_trk_q);
  assign pick_trk = trk_req & (~cal_req | ~last_trk_q);
  assign pick_steps = pick_trk ? trk_num_steps : cal_num_steps;

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[META_REGS-2:0], phs_shft_busy};
    last_trk_d  = last_trk_q;
    own_trk_d   = own_trk_q;
    rem_d       = rem_q;
    tmr_d       = tmr_q;
    start_d     = 1'b0;
    sel_d       = sel_q;
    inc_d       = inc_q;
    cal_grant_d = cal_grant_q;
    trk_grant_d = trk_grant_q;
    cal_ack_d   = 1'b0;
    trk_ack_d   = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_cal || pick_trk) begin
          own_trk_d   = pick_trk;
          last_trk_d  = pick_trk;
          sel_d       = pick_trk ? trk_clk_index : cal_clk_index;
          inc_d       = pick_trk ? trk_inc_dec_n : cal_inc_dec_n;
          rem_d       = pick_steps;
          cal_grant_d = pick_cal;
          trk_grant_d = pick_trk;
          tmr_d       = '0;
          if (pick_steps == '0) begin
            state_d   = DONE;
            cal_ack_d = pick_cal;
            trk_ack_d = pick_trk;
          end else begin
            state_d = START;
            start_d = 1'b1;
          end
        end
      end
      START: begin
        tmr_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // Fall through on timer in case the busy pulse was too short to sync.
        if (busy_s || tmr_q == TMR_W'(BUSY_WAIT_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = WAIT_LO;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WAIT_LO: begin
        if (!busy_s) begin
          rem_d = rem_q - STEP_CNT_WIDTH'(1);
          if (rem_q == STEP_CNT_WIDTH'(1)) begin
            state_d   = DONE;
            cal_ack_d = ~own_trk_q;
            trk_ack_d = own_trk_q;
          end else begin
            state_d = START;
            start_d = 1'b1;
          end
        end
`ifdef PLL_PHASE_ARB_TIMEOUT_EN
        else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          err_d     = 1'b1;
          rem_d     = '0;
          state_d   = DONE;
          cal_ack_d = ~own_trk_q;
          trk_ack_d = own_trk_q;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
`endif
      end
      DONE: begin
        cal_grant_d = 1'b0;
        trk_grant_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge seq_clk) begin
    if (reset_seq) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      last_trk_q  <= 1'b1;
      own_trk_q   <= 1'b0;
      rem_q       <= '0;
      tmr_q       <= '0;
      start_q     <= 1'b0;
      sel_q       <= '0;
      inc_q       <= 1'b0;
      cal_grant_q <= 1'b0;
      trk_grant_q <= 1'b0;
      cal_ack_q   <= 1'b0;
      trk_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      last_trk_q  <= last_trk_d;
      own_trk_q   <= own_trk_d;
      rem_q       <= rem_d;
      tmr_q       <= tmr_d;
      start_q     <= start_d;
      sel_q       <= sel_d;
      inc_q       <= inc_d;
      cal_grant_q <= cal_grant_d;
      trk_grant_q <= trk_grant_d;
      cal_ack_q   <= cal_ack_d;
      trk_ack_q   <= trk_ack_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign cal_grant              = cal_grant_q;
  assign cal_ack                = cal_ack_q;
  assign trk_grant              = trk_grant_q;
  assign trk_ack                = trk_ack_q;
  assign seq_pll_start_reconfig = start_q;
  assign seq_pll_select         = sel_q;
  assign seq_pll_inc_dec_n      = inc_q;
  assign arb_busy               = busy_q;
  assign arb_timeout_err        = err_q;

endmodule

// File: tb/tb_ddr2_24x64_8_phy_alt_mem_phy_pll_phase_arbiter.sv
// Directed bench for the PLL phase arbiter; busy model keyed off start pulses.
// Define PLL_PHASE_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_ddr2_24x64_8_phy_alt_mem_phy_pll_phase_arbiter;

  logic       seq_clk = 1'b0;
  logic       reset_seq;
  logic       cal_req, trk_req;
  logic [3:0] cal_clk_index, trk_clk_index;
  logic       cal_inc_dec_n, trk_inc_dec_n;
  logic [5:0] cal_num_steps, trk_num_steps;
  logic       cal_grant, cal_ack, trk_grant, trk_ack;
  logic       phs_shft_busy;
  logic       seq_pll_start_reconfig;
  logic [3:0] seq_pll_select;
  logic       seq_pll_inc_dec_n;
  logic       arb_busy, arb_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  int busy_mode = 0;
  int bcnt      = 0;

  int n_start   = 0;
  int n_cal_ack = 0;
  int n_trk_ack = 0;
  int n_trk_gnt = 0;
  int sel_bad   = 0;

  always #5 seq_clk = ~seq_clk;

  ddr2_24x64_8_phy_alt_mem_phy_pll_phase_arbiter dut (
    .seq_clk                (seq_clk),
    .reset_seq              (reset_seq),
    .cal_req                (cal_req),
    .cal_clk_index          (cal_clk_index),
    .cal_inc_dec_n          (cal_inc_dec_n),
    .cal_num_steps          (cal_num_steps),
    .cal_grant              (cal_grant),
    .cal_ack                (cal_ack),
    .trk_req                (trk_req),
    .trk_clk_index          (trk_clk_index),
    .trk_inc_dec_n          (trk_inc_dec_n),
    .trk_num_steps          (trk_num_steps),
    .trk_grant              (trk_grant),
    .trk_ack                (trk_ack),
    .phs_shft_busy          (phs_shft_busy),
    .seq_pll_start_reconfig (seq_pll_start_reconfig),
    .seq_pll_select         (seq_pll_select),
    .seq_pll_inc_dec_n      (seq_pll_inc_dec_n),
    .arb_busy               (arb_busy),
    .arb_timeout_err        (arb_timeout_err)
  );

  // PLL model: busy high for 4 cycles, starting 2 cycles after a pulse.
  always @(posedge seq_clk) begin
    if (seq_pll_start_reconfig) bcnt <= 1;
    else if (bcnt != 0 && bcnt < 6) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  assign phs_shft_busy = (busy_mode == 2) ? 1'b1 :
                         (busy_mode == 1) ? 1'b0 :
                         (bcnt >= 2 && bcnt <= 5);

  always @(posedge seq_clk) begin
    n_start   <= n_start + int'(seq_pll_start_reconfig);
    n_cal_ack <= n_cal_ack + int'(cal_ack);
    n_trk_ack <= n_trk_ack + int'(trk_ack);
    n_trk_gnt <= n_trk_gnt + int'(trk_grant);
    if ((cal_grant && (seq_pll_select !== cal_clk_index ||
                       seq_pll_inc_dec_n !== cal_inc_dec_n)) ||
        (trk_grant && (seq_pll_select !== trk_clk_index ||
                       seq_pll_inc_dec_n !== trk_inc_dec_n)))
      sel_bad <= sel_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int bound, output int cyc,
                          output logic [1:0] who);
    cyc = 0;
    who = 2'b00;
    while (cyc < bound && who == 2'b00) begin
      @(negedge seq_clk);
      cyc++;
      who = {cal_ack, trk_ack};
    end
  endtask

  task automatic do_reset();
    reset_seq = 1'b1;
    repeat (3) @(negedge seq_clk);
    reset_seq = 1'b0;
    @(negedge seq_clk);
  endtask

  int b_s, b_ca, b_ta, b_tg, b_bad, cyc;
  logic [1:0] who;

  initial begin
    reset_seq = 1'b1;
    cal_req = 0; trk_req = 0;
    cal_clk_index = 0; trk_clk_index = 0;
    cal_inc_dec_n = 0; trk_inc_dec_n = 0;
    cal_num_steps = 0; trk_num_steps = 0;
    repeat (3) @(negedge seq_clk);
    chk("reset_outs", {cal_grant, cal_ack, trk_grant, trk_ack,
        seq_pll_start_reconfig, seq_pll_select, seq_pll_inc_dec_n,
        arb_busy, arb_timeout_err}, 0);
    reset_seq = 1'b0;
    @(negedge seq_clk);

    // basic: cal, idx 5, inc, 3 steps
    b_s = n_start; b_ca = n_cal_ack; b_tg = n_trk_gnt; b_bad = sel_bad;
    cal_clk_index = 4'd5; cal_inc_dec_n = 1; cal_num_steps = 6'd3;
    cal_req = 1;
    @(negedge seq_clk);
    chk("basic_grant_start", {cal_grant, seq_pll_start_reconfig}, 2'b11);
    wait_ack(100, cyc, who);
    chk("basic_ack_who", who, 2'b10);
    chk("basic_latency", cyc + 1, 28);
    cal_req = 0;
    @(negedge seq_clk);
    chk("basic_starts", n_start - b_s, 3);
    chk("basic_acks", n_cal_ack - b_ca, 1);
    chk("basic_trk_grant", n_trk_gnt - b_tg, 0);
    chk("basic_sel", sel_bad - b_bad, 0);
    chk("basic_idle", {arb_busy, cal_grant}, 0);

    // round robin from reset
    do_reset();
    b_bad = sel_bad;
    cal_clk_index = 4'd3; cal_inc_dec_n = 1; cal_num_steps = 6'd1;
    trk_clk_index = 4'd9; trk_inc_dec_n = 0; trk_num_steps = 6'd1;
    cal_req = 1; trk_req = 1;
    @(negedge seq_clk);
    chk("rr_first_grant", {cal_grant, trk_grant}, 2'b10);
    wait_ack(100, cyc, who);
    chk("rr_first_ack", who, 2'b10);
    cal_req = 0;
    @(negedge seq_clk);
    @(negedge seq_clk);
    chk("rr_trk_sel", {trk_grant, seq_pll_select, seq_pll_inc_dec_n},
        {1'b1, 4'd9, 1'b0});
    wait_ack(100, cyc, who);
    chk("rr_second_ack", who, 2'b01);
    trk_req = 0;
    @(negedge seq_clk);
    cal_req = 1; trk_req = 1;
    wait_ack(100, cyc, who);
    chk("rr_third_ack", who, 2'b10);
    cal_req = 0;
    wait_ack(100, cyc, who);
    chk("rr_fourth_ack", who, 2'b01);
    trk_req = 0;
    @(negedge seq_clk);
    chk("rr_sel", sel_bad - b_bad, 0);

    // zero steps
    b_s = n_start;
    cal_num_steps = 6'd0; cal_req = 1;
    @(negedge seq_clk);
    chk("zero_grant_ack", {cal_grant, cal_ack, seq_pll_start_reconfig},
        3'b110);
    cal_req = 0;
    @(negedge seq_clk);
    chk("zero_idle", {cal_grant, cal_ack, arb_busy}, 0);
    chk("zero_starts", n_start - b_s, 0);

    // busy never rises
    busy_mode = 1;
    @(negedge seq_clk);
    b_s = n_start; b_ta = n_trk_ack;
    trk_clk_index = 4'd2; trk_inc_dec_n = 1; trk_num_steps = 6'd2;
    trk_req = 1;
    wait_ack(100, cyc, who);
    chk("nobusy_ack_who", who, 2'b01);
    chk("nobusy_latency", cyc, 21);
    trk_req = 0;
    @(negedge seq_clk);
    chk("nobusy_starts", n_start - b_s, 2);
    chk("nobusy_acks", n_trk_ack - b_ta, 1);
    busy_mode = 0;

    // reset in WAIT_LO of step 2 of 4
    repeat (8) @(negedge seq_clk);
    cal_clk_index = 4'd6; cal_inc_dec_n = 0; cal_num_steps = 6'd4;
    cal_req = 1;
    repeat (16) @(negedge seq_clk);
    chk("mid_owned", {cal_grant, seq_pll_start_reconfig, arb_busy}, 3'b101);
    reset_seq = 1'b1;
    @(negedge seq_clk);
    b_ca = n_cal_ack;
    chk("mid_reset_outs", {cal_grant, cal_ack, trk_grant, trk_ack,
        seq_pll_start_reconfig, seq_pll_select, seq_pll_inc_dec_n,
        arb_busy, arb_timeout_err}, 0);
    reset_seq = 1'b0;
    @(negedge seq_clk);
    chk("mid_regrant", {cal_grant, seq_pll_start_reconfig}, 2'b11);
    chk("mid_no_ack", n_cal_ack - b_ca, 0);
    b_s = n_start;
    wait_ack(100, cyc, who);
    chk("mid_ack_who", who, 2'b10);
    chk("mid_latency", cyc + 1, 37);
    cal_req = 0;
    @(negedge seq_clk);
    chk("mid_starts", n_start - b_s, 4);

`ifdef PLL_PHASE_ARB_TIMEOUT_EN
    busy_mode = 2;
    repeat (4) @(negedge seq_clk);
    b_s = n_start;
    cal_num_steps = 6'd2; cal_req = 1;
    wait_ack(1300, cyc, who);
    chk("to_ack_who", who, 2'b10);
    chk("to_err", arb_timeout_err, 1);
    cal_req = 0;
    repeat (5) @(negedge seq_clk);
    chk("to_sticky", {arb_timeout_err, arb_busy}, 2'b10);
    chk("to_starts", n_start - b_s, 1);
    busy_mode = 0;
    do_reset();
    chk("to_cleared", arb_timeout_err, 0);
`else
    chk("no_err_default", arb_timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
